mem_wb_hilo: RTL

- Consumer end of the MEM-stage writeback interface.
- Registers the MEM outputs into the WB stage (MEM/WB pipeline register) and drives the register-file write port.
- Holds the architectural HI/LO registers, updated from the WB stage.
- Provides a forwarded HI/LO read port to EX, so MFHI/MFLO see in-flight MEM/WB writes.

---
 rtl/mem_wb_hilo.sv | 110 +++++++++++
 1 files changed

// File: rtl/mem_wb_hilo.sv
// Purpose: MEM/WB pipeline register, architectural HI/LO registers and HI/LO bypass to EX.
// Latency: mem_* -> wb_* one cycle; wb_hi/wb_lo -> hi_o/lo_o one further cycle; ex_hi/ex_lo combinational.
// Backpressure: stall=2'b00 advances, stall=2'b10 inserts a bubble, any other stall code holds WB; flush inserts a bubble.
//
// Build option: define HILO_FWD_EN to bypass in-flight MEM/WB HI/LO writes onto ex_hi/ex_lo.
// Without it ex_hi/ex_lo are the architectural registers, and the hazard unit must stall EX
// for two cycles after any HI/LO-writing instruction.
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-low reset
//   stall[1:0], flush             bit1 = MEM stalled, bit0 = WB stalled; synchronous bubble request
//   mem_wd/mem_wreg/mem_wdata     GPR write request from MEM
//   mem_hi/mem_lo/mem_whilo       HI/LO write request from MEM
//   wb_wd/wb_wreg/wb_wdata        register-file write port
//   wb_hi/wb_lo/wb_whilo          WB-stage HI/LO write request
//   hi_o/lo_o                     architectural HI/LO
//   ex_hi/ex_lo                   HI/LO as seen by an MFHI/MFLO in EX
module mem_wb_hilo #(
    parameter int REG_W    = 32,
    parameter int ADDR_W   = 5,
    parameter int NOP_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic              mem_wreg,
    input  logic [REG_W-1:0]  mem_wdata,
    input  logic [REG_W-1:0]  mem_hi,
    input  logic [REG_W-1:0]  mem_lo,
    input  logic              mem_whilo,
    output logic [ADDR_W-1:0] wb_wd,
    output logic              wb_wreg,
    output logic [REG_W-1:0]  wb_wdata,
    output logic [REG_W-1:0]  wb_hi,
    output logic [REG_W-1:0]  wb_lo,
    output logic              wb_whilo,
    output logic [REG_W-1:0]  hi_o,
    output logic [REG_W-1:0]  lo_o,
    output logic [REG_W-1:0]  ex_hi,
    output logic [REG_W-1:0]  ex_lo
);

    localparam logic [ADDR_W-1:0] NOP_WD = ADDR_W'(NOP_ADDR);

    // A bubble is a flush or a stalled MEM feeding a free WB stage.
    logic load_bubble;
    logic advance;

    assign load_bubble = flush || (stall == 2'b10);
    // Only a fully free pipe advances; the illegal 2'b01 code falls through to hold.
    assign advance     = (stall == 2'b00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_wd    <= NOP_WD;
            wb_wreg  <= 1'b0;
            wb_wdata <= '0;
            wb_hi    <= '0;
            wb_lo    <= '0;
            wb_whilo <= 1'b0;
        end else if (load_bubble) begin
            wb_wd    <= NOP_WD;
            wb_wreg  <= 1'b0;
            wb_wdata <= '0;
            wb_hi    <= '0;
            wb_lo    <= '0;
            wb_whilo <= 1'b0;
        end else if (advance) begin
            wb_wd    <= mem_wd;
            wb_wreg  <= mem_wreg;
            wb_wdata <= mem_wdata;
            wb_hi    <= mem_hi;
            wb_lo    <= mem_lo;
            wb_whilo <= mem_whilo;
        end
    end

    // Commit ignores stall and flush: a held WB rewrites the same value, and a flush
    // only replaces what enters WB, not the instruction already leaving it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_o <= '0;
            lo_o <= '0;
        end else if (wb_whilo) begin
            hi_o <= wb_hi;
            lo_o <= wb_lo;
        end
    end

`ifdef HILO_FWD_EN
    // Youngest producer wins: MEM, then WB, then the architectural value.
    always_comb begin
        ex_hi = hi_o;
        ex_lo = lo_o;
        if (mem_whilo) begin
            ex_hi = mem_hi;
            ex_lo = mem_lo;
        end else if (wb_whilo) begin
            ex_hi = wb_hi;
            ex_lo = wb_lo;
        end
    end
`else
    assign ex_hi = hi_o;
    assign ex_lo = lo_o;
`endif

endmodule
